buzzer_sequencer: RTL

Autonomous note sequencer for the buzzer tone generator. The CPU preloads a note table of (note code, duration in ms) entries and programs song length, loop count and inter-loop gap, then pulses start. The block steps through the table on a millisecond timebase and drives note code plus tone enable into the tone generator, so the CPU does not have to time each note.

---
 rtl/buzzer_sequencer_if.sv | 29 ++
 rtl/buzzer_sequencer.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/buzzer_sequencer_if.sv
// CPU-side control and status bundle of the buzzer note sequencer.
// The master drives table writes and song controls; the slave returns tone and status.
interface buzzer_sequencer_if #(
    parameter int AW = 7
);
    logic          wrEn;
    logic [AW-1:0] wrAddr;
    logic [31:0]   wrData;
    logic [AW:0]   songLen;
    logic [7:0]    loopCount;
    logic [15:0]   gapMs;
    logic          start;
    logic          stop;
    logic [3:0]    noteCode;
    logic          toneEn;
    logic          busy;
    logic [AW-1:0] notePos;
    logic          done;

    modport master (
        output wrEn, wrAddr, wrData, songLen, loopCount, gapMs, start, stop,
        input  noteCode, toneEn, busy, notePos, done
    );

    modport slave (
        input  wrEn, wrAddr, wrData, songLen, loopCount, gapMs, start, stop,
        output noteCode, toneEn, busy, notePos, done
    );
endinterface

// File: rtl/buzzer_sequencer.sv
// Autonomous note sequencer: steps a preloaded note table on a millisecond timebase
// and drives note code plus tone enable into the buzzer tone generator.
module buzzer_sequencer #(
    parameter int DEPTH    = 128,
    parameter int AW       = 7,
    parameter int TICK_DIV = 50000
) (
    input logic               clk,
    input logic               rstn,
    buzzer_sequencer_if.slave bus
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {IDLE, FETCH, PLAY, GAP} seqStateT;

    seqStateT      state;
    logic [PW-1:0] prescaler;
    logic [AW:0]   songLenQ;
    logic [7:0]    loopsLeft;
    logic [15:0]   gapQ;
    logic [15:0]   gapCnt;
    logic [15:0]   durCnt;
    logic [AW-1:0] notePos;
    logic [3:0]    noteCode;
    logic          toneEn;
    logic          busy;
    logic          done;

    // Only the duration and note-code fields are kept: entry = {duration, code}.
    logic [19:0]   mem [DEPTH];
    logic [19:0]   rdEntry;
    logic [AW-1:0] rdAddr;
    logic [AW:0]   posNext;
    logic          tick;
    logic          advance;
    logic          passEnd;
    logic          unusedWrBits;

    assign unusedWrBits = ^bus.wrData[15:4];

    assign tick    = (prescaler == PW'(TICK_DIV - 1));
    assign posNext = {1'b0, notePos} + (AW+1)'(1);
    assign advance = (state == PLAY) && (posNext < songLenQ);
    // Address the entry the next FETCH will need, so the registered read lands in time.
    assign rdAddr  = advance ? posNext[AW-1:0] : '0;
    assign passEnd = ((state == FETCH) && (rdEntry[19:4] == 16'd0)) ||
                     ((state == PLAY) && tick && (durCnt == 16'd1) && !advance);

    // NOTE: the note table has no reset; only control state is cleared by rstn.
    always_ff @(posedge clk) begin
        if (bus.wrEn) mem[bus.wrAddr] <= {bus.wrData[31:16], bus.wrData[3:0]};
        rdEntry <= mem[rdAddr];
    end

    // NOTE: non-blocking assignments throughout, so later overrides in the block win cleanly.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            prescaler <= '0;
            songLenQ  <= '0;
            loopsLeft <= '0;
            gapQ      <= '0;
            gapCnt    <= '0;
            durCnt    <= '0;
            notePos   <= '0;
            noteCode  <= '0;
            toneEn    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done      <= 1'b0;
            prescaler <= ((state == PLAY || state == GAP) && !tick) ? prescaler + PW'(1) : '0;
            if (bus.stop) begin
                state     <= IDLE;
                prescaler <= '0;
                noteCode  <= '0;
                toneEn    <= 1'b0;
                busy      <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (bus.start && (bus.songLen != '0)) begin
                            songLenQ  <= bus.songLen;
                            loopsLeft <= (bus.loopCount == 8'd0) ? 8'd1 : bus.loopCount;
                            gapQ      <= bus.gapMs;
                            notePos   <= '0;
                            busy      <= 1'b1;
                            state     <= FETCH;
                        end
                    end
                    FETCH: begin
                        if (rdEntry[19:4] != 16'd0) begin
                            durCnt   <= rdEntry[19:4];
                            noteCode <= rdEntry[3:0];
                            toneEn   <= 1'b1;
                            state    <= PLAY;
                        end
                    end
                    PLAY: begin
                        if (tick) begin
                            if (durCnt != 16'd1) begin
                                durCnt <= durCnt - 16'd1;
                            end else if (advance) begin
                                notePos  <= posNext[AW-1:0];
                                noteCode <= '0;
                                toneEn   <= 1'b0;
                                state    <= FETCH;
                            end
                        end
                    end
                    GAP: begin
                        if (tick) begin
                            if (gapCnt == 16'd1) state <= FETCH;
                            else                 gapCnt <= gapCnt - 16'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
                if (passEnd) begin
                    noteCode <= '0;
                    toneEn   <= 1'b0;
                    if (loopsLeft == 8'd1) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        loopsLeft <= loopsLeft - 8'd1;
                        notePos   <= '0;
                        if (gapQ != 16'd0) begin
                            gapCnt <= gapQ;
                            state  <= GAP;
                        end else begin
                            state  <= FETCH;
                        end
                    end
                end
            end
        end
    end

    assign bus.noteCode = noteCode;
    assign bus.toneEn   = toneEn;
    assign bus.busy     = busy;
    assign bus.notePos  = notePos;
    assign bus.done     = done;
endmodule
